spi_tx_mode03: RTL
==================

Name: spi_tx_mode03

Overview:
- SPI master transmit stage for SPI modes 0 and 3 (CPHA = CPOL).
- Accepts one parallel byte per start handshake and generates sclk and ss_n.
- Serialises the byte on mosi, MSB- or LSB-first as selected by LSBFE.
- Sits directly upstream of the mode 0/3 receiver: mosi feeds the receiver data_in and ready feeds the receiver ready.

Parameters:
- CLK_DIV, 2, sclk half-period in clk cycles; legal range 1..255.
- DATA_W, 8, frame width in bits; only 8 is verified.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low.
- start  input  1  request a transfer; accepted only in IDLE.
- tx_data  input  8  byte to send; captured on the accepted start.
- LSBFE  input  1  1 = send tx_data[0] first, 0 = send tx_data[7] first; captured on start.
- CPOL  input  1  0 = mode 0 (sclk idles low), 1 = mode 3 (sclk idles high); captured on start.
- sclk  output  1  serial clock.
- mosi  output  1  serial data out.
- ss_n  output  1  slave select, active-low.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse at transfer end.
- ready  output  1  equals ~ss_n; drives the receiver ready input.

Behaviour:
- Reset (rst=0 at posedge) values: sclk=0, mosi=0, ss_n=1, busy=0, done=0, ready=0; FSM to IDLE; counters cleared. Reset takes effect mid-transfer: the frame is aborted with no done pulse.
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - sclk <= CPOL input each cycle; mosi=0; ss_n=1.
  - When start=1 at a posedge (call this cycle 0): latch tx_data, LSBFE and CPOL. Go to SETUP with ss_n=0, busy=1, and mosi = first bit, all valid from cycle 1.
- SETUP: wait CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - A half-period counter toggles sclk every CLK_DIV cycles. Edge k (k=1..16) is visible at cycle 1+k*CLK_DIV.
  - Rising edges are the sample points; the receiver samples on the rising sclk.
  - mosi changes only on a falling edge that follows a rising edge (next bit in LSBFE order).
  - Mode 3: edge 1 is falling with no data change; edges 2, 4, …, 16 are rising.
  - Mode 0: odd edges are rising; the final falling edge 16 does not change mosi.
  - After edge 16, sclk is back at its idle level. Go to HOLD.
- HOLD:
  - Keep ss_n=0 for CLK_DIV cycles.
  - Then ss_n=1, busy=0, done=1 for one cycle (cycle 1+17*CLK_DIV), mosi=0, and return to IDLE.
- A new start is accepted in the cycle done is high, i.e. back-to-back frames are allowed.
- start while busy is ignored. Changes to tx_data, LSBFE or CPOL during a frame have no effect.
- Bit counter is 3 bits and counts rising edges; it wraps 7→0 on the 8th rising edge with no side effect.
- Exactly 8 rising edges and 16 total edges per frame.

Decomposition:
- Shared package spi_pkg holds:
  - FSM state encodings (IDLE/SETUP/SHIFT/HOLD, 2-bit).
  - Mode constants MODE0 = CPOL 0, MODE3 = CPOL 1.
  - DATA_W default.
- One sub-module, spi_sclk_gen: half-period divider plus edge counter. Outputs sclk, rise_pulse, fall_pulse and last_edge; inputs en, cpol and div.
- Shift register and FSM stay in spi_tx_mode03.

Test Plan:
- Mode 0, MSB-first: CLK_DIV=2, CPOL=0, LSBFE=0, tx_data=8'hA5, start at cycle 0.
  - ss_n low at cycle 1; rising edges at cycles 3,7,…,31.
  - mosi sampled at the rising edges = 1,0,1,0,0,1,0,1.
  - done at cycle 35; sclk ends low.
- Mode 3, LSB-first: CPOL=1, LSBFE=1, tx_data=8'h3C.
  - sclk idles high; first edge falling at cycle 3.
  - Bits sampled at the rising edges = 0,0,1,1,1,1,0,0.
  - sclk high after the frame; done at cycle 35.
- Loopback with the mode 0/3 receiver (mosi→data_in, ready→ready), modes 0 and 3, both LSBFE values, bytes 00, FF, 81, 5A.
  - Receiver store_data equals tx_data after each frame.
- Protocol edges:
  - start asserted during busy: no effect.
  - start held high across done: a second frame starts immediately, with exactly 16 edges each.
  - tx_data changed mid-frame: the transmitted byte is unchanged.
- Reset: drive rst=0 at cycle 10 of a frame.
  - Next cycle: ss_n=1, sclk=0, busy=0, no done pulse.
  - A subsequent start sends a full, correct frame.
- CLK_DIV=1 (sclk toggles every clk cycle): 16 edges at cycles 2..17; done at cycle 18; data correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode 0/3 transmit slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    // Transmit FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    // CPHA follows CPOL, so the mode is fully described by the CPOL bit.
    localparam logic MODE0 = 1'b0;
    localparam logic MODE3 = 1'b1;

    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI serial clock generator: half-period divider plus edge counter.
// Latency: first toggle i_div cycles after i_en rises; one toggle per i_div cycles after that.
// Backpressure: none; i_en low holds sclk at the idle level and clears all counts.
// Ports: i_clk/i_rst (sync, active-low), i_en, i_cpol (idle level), i_div (half-period),
//        o_sclk, o_rise_pulse/o_fall_pulse (edge happening at this posedge), o_last_edge.
module spi_sclk_gen #(
    parameter int DATA_W = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_cpol,
    input  logic [7:0] i_div,
    output logic       o_sclk,
    output logic       o_rise_pulse,
    output logic       o_fall_pulse,
    output logic       o_last_edge
);
    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    logic [7:0]    r_cnt;
    logic [EW-1:0] r_edge_cnt;
    logic          r_sclk;
    logic          w_tick;

    // The pulses are combinational so the caller acts on the same posedge
    // that moves sclk.
    assign w_tick       = i_en && (r_cnt == i_div - 8'd1);
    assign o_rise_pulse = w_tick && !r_sclk;
    assign o_fall_pulse = w_tick &&  r_sclk;
    assign o_last_edge  = w_tick && (r_edge_cnt == LAST_EDGE);
    assign o_sclk       = r_sclk;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt      <= '0;
            r_edge_cnt <= '0;
            r_sclk     <= 1'b0;
        end else if (!i_en) begin
            r_cnt      <= '0;
            r_edge_cnt <= '0;
            r_sclk     <= i_cpol;
        end else if (w_tick) begin
            r_cnt      <= '0;
            r_edge_cnt <= r_edge_cnt + 1'b1;
            r_sclk     <= ~r_sclk;
        end else begin
            r_cnt      <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_tx_mode03.sv
// SPI master transmitter, modes 0 and 3, MSB- or LSB-first byte framing.
// Latency: ss_n/busy/first bit one cycle after start; done pulse 1+17*CLK_DIV cycles after start.
// Backpressure: start is only taken in IDLE (including the done cycle); start while busy is dropped.
// Ports: i_clk, i_rst (sync, active-low), i_start, i_tx_data, i_lsbfe, i_cpol;
//        o_sclk, o_mosi, o_ss_n, o_busy, o_done (1-cycle), o_ready (= ~o_ss_n).
module spi_tx_mode03
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_lsbfe,
    input  logic              i_cpol,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_ss_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ready
);
    localparam logic [7:0] DIV = 8'(CLK_DIV);
    localparam int         BW  = $clog2(DATA_W);

    spi_state_t        r_state;
    spi_state_t        w_next;
    logic              w_accept;
    logic [DATA_W-1:0] r_data;
    logic              r_lsbfe;
    logic              r_cpol;
    logic [BW-1:0]     r_bit_cnt;
    logic [7:0]        r_hold_cnt;
    logic              r_mosi;
    logic              r_ss_n;
    logic              r_busy;
    logic              r_done;

    logic              w_gen_en;
    logic              w_gen_cpol;
    logic              w_sclk;
    logic              w_rise;
    logic              w_fall;
    logic              w_last;
    logic              w_shift;
    logic              w_hold_end;
    logic [BW-1:0]     w_idx;

    // In IDLE sclk tracks the live CPOL pin; once a frame starts it uses the
    // captured copy so pin changes cannot disturb the frame.
    assign w_gen_en   = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
    assign w_gen_cpol = (r_state == ST_IDLE) ? i_cpol : r_cpol;

    spi_sclk_gen #(
        .DATA_W (DATA_W)
    ) u_sclk_gen (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (w_gen_en),
        .i_cpol       (w_gen_cpol),
        .i_div        (DIV),
        .o_sclk       (w_sclk),
        .o_rise_pulse (w_rise),
        .o_fall_pulse (w_fall),
        .o_last_edge  (w_last)
    );

    // Edge 1 always happens in SETUP, so a falling edge seen in SHIFT has a
    // rising edge before it (covers the mode 3 leading fall). The last edge
    // is a fall only in mode 0, and must not advance mosi.
    assign w_shift    = w_fall && (r_state == ST_SHIFT) && !w_last;
    assign w_hold_end = (r_state == ST_HOLD) && (r_hold_cnt == DIV - 8'd1);

    // r_bit_cnt counts rising edges, i.e. bits already sampled; that is also
    // the time-order index of the next bit to present.
    assign w_idx = r_lsbfe ? r_bit_cnt : (BW'(DATA_W - 1) - r_bit_cnt);

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    w_next   = ST_SETUP;
                end
            end
            ST_SETUP: if (w_rise || w_fall) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last)           w_next = ST_HOLD;
            ST_HOLD:  if (w_hold_end)       w_next = ST_IDLE;
            default:                        w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_data     <= '0;
            r_lsbfe    <= 1'b0;
            r_cpol     <= 1'b0;
            r_bit_cnt  <= '0;
            r_hold_cnt <= '0;
            r_mosi     <= 1'b0;
            r_ss_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_data    <= i_tx_data;
                r_lsbfe   <= i_lsbfe;
                r_cpol    <= i_cpol;
                r_bit_cnt <= '0;
                r_ss_n    <= 1'b0;
                r_busy    <= 1'b1;
                r_mosi    <= i_lsbfe ? i_tx_data[0] : i_tx_data[DATA_W-1];
            end
            // Wraps to zero on the final rising edge; nothing depends on it after that.
            if (w_rise) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift) r_mosi <= r_data[w_idx];
            if (r_state == ST_SHIFT && w_last) r_hold_cnt <= '0;
            else if (r_state == ST_HOLD)       r_hold_cnt <= r_hold_cnt + 8'd1;
            if (w_hold_end) begin
                r_ss_n <= 1'b1;
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_mosi <= 1'b0;
            end
        end
    end

    assign o_sclk  = w_sclk;
    assign o_mosi  = r_mosi;
    assign o_ss_n  = r_ss_n;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_ready = ~r_ss_n;

endmodule
